// File: rtl/sys_defs.sv
// Shared ROB/CDB definitions: tag type, CDB packet layout and the ROB age helper.
package sys_defs;

  localparam int SYS_TAG_W  = 4;
  localparam int SYS_ROB_SZ = 8;

  typedef logic [SYS_TAG_W-1:0] ROB_TAG;

  typedef struct packed {
    logic        valid;
    ROB_TAG      tag;
    logic [31:0] value;
    logic        mispred;
    logic [31:0] branch_loc;
  } cdb_packet_t;

  // Distance of a tag from the ROB head; tags wrap over 1..rob_sz.
  function automatic int unsigned rob_age(input ROB_TAG tag, input ROB_TAG head,
                                          input int unsigned rob_sz);
    int unsigned t;
    int unsigned h;
    t = 32'(tag);
    h = 32'(head);
    return (t >= h) ? (t - h) : (t + rob_sz - h);
  endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Round-robin picker: first requester at or after ptr, scanning upward with wrap.
module cdb_rr_picker #(
  parameter int NUM_FU = 4,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_FU-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_FU-1:0] grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding buffer per FU, one broadcast per cycle, squash-aware.
// Define CDB_ARB_AGE_PRIO_EN to pick the oldest buffer instead of round-robin.
module cdb_arbiter
  import sys_defs::*;
#(
  parameter int NUM_FU = 4,
  parameter int ROB_SZ = 8,
  parameter int TAG_W  = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_FU-1:0]              fu_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0]   fu_tag,
  input  logic [NUM_FU-1:0][31:0]        fu_value,
  input  logic [NUM_FU-1:0]              fu_mispred,
  input  logic [NUM_FU-1:0][31:0]        fu_branch_loc,
  output logic [NUM_FU-1:0]              fu_ready,
  input  logic [TAG_W-1:0]               rob_head,
  input  logic                           squash_valid,
  input  logic [TAG_W-1:0]               squash_tag,
  output logic                           cdb_valid,
  output logic [TAG_W-1:0]               cdb_tag,
  output logic [31:0]                    cdb_value,
  output logic                           cdb_mispred,
  output logic [31:0]                    cdb_branch_loc
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  cdb_packet_t              buf_q [NUM_FU];
  cdb_packet_t              cdb_q;
  cdb_packet_t              win_pkt;
  logic [NUM_FU-1:0]        occ;
  logic [NUM_FU-1:0]        squash_hit;
  logic [NUM_FU-1:0]        cap_drop;
  logic [NUM_FU-1:0]        req;
  logic [NUM_FU-1:0]        grant;
  logic [NUM_FU-1:0]        capture;
  logic [PTR_W-1:0]         win_idx;
  logic                     any_grant;
  int unsigned              sq_age;

  // Squashed buffers are removed from the request set so they can never win.
  always_comb begin
    sq_age     = rob_age(squash_tag, rob_head, ROB_SZ);
    occ        = '0;
    squash_hit = '0;
    cap_drop   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      occ[i]        = buf_q[i].valid;
      squash_hit[i] = squash_valid && buf_q[i].valid &&
                      (rob_age(buf_q[i].tag, rob_head, ROB_SZ) > sq_age);
      cap_drop[i]   = squash_valid && (rob_age(fu_tag[i], rob_head, ROB_SZ) > sq_age);
    end
    req = occ & ~squash_hit;
  end

`ifdef CDB_ARB_AGE_PRIO_EN
  int unsigned best_age;
  int unsigned cur_age;
  logic        found;

  // Strict less-than keeps ties on the lowest index.
  always_comb begin
    grant    = '0;
    best_age = '0;
    cur_age  = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      cur_age = rob_age(buf_q[i].tag, rob_head, ROB_SZ);
      if (req[i] && (!found || cur_age < best_age)) begin
        grant    = '0;
        grant[i] = 1'b1;
        best_age = cur_age;
        found    = 1'b1;
      end
    end
  end
`else
  logic [PTR_W-1:0] ptr_q;

  cdb_rr_picker #(
    .NUM_FU (NUM_FU),
    .PTR_W  (PTR_W)
  ) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      ptr_q <= '0;
    else if (any_grant)
      ptr_q <= (32'(win_idx) == NUM_FU - 1) ? '0 : win_idx + 1'b1;
  end
`endif

  always_comb begin
    win_pkt = '0;
    win_idx = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        win_pkt = buf_q[i];
        win_idx = PTR_W'(i);
      end
    end
    any_grant = |grant;
  end

  // A granted buffer frees up in the same cycle, so its FU may refill it.
  assign fu_ready = ~occ | grant;

  always_comb begin
    capture = '0;
    for (int i = 0; i < NUM_FU; i++)
      capture[i] = fu_valid[i] && fu_ready[i] && (fu_tag[i] != '0) && !cap_drop[i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) buf_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (capture[i])
          buf_q[i] <= '{valid: 1'b1, tag: fu_tag[i], value: fu_value[i],
                        mispred: fu_mispred[i], branch_loc: fu_branch_loc[i]};
        else if (grant[i] || squash_hit[i])
          buf_q[i] <= '0;
      end
    end
  end

  // win_pkt is all-zero when nothing is granted, which idles the bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cdb_q <= '0;
    else       cdb_q <= win_pkt;
  end

  assign cdb_valid      = cdb_q.valid;
  assign cdb_tag        = cdb_q.tag;
  assign cdb_value      = cdb_q.value;
  assign cdb_mispred    = cdb_q.mispred;
  assign cdb_branch_loc = cdb_q.branch_loc;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic against a buffer-level model.
module tb_cdb_arbiter;

  localparam int NF = 4;
  localparam int RS = 8;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [NF-1:0]          fu_valid;
  logic [NF-1:0][3:0]     fu_tag;
  logic [NF-1:0][31:0]    fu_value;
  logic [NF-1:0]          fu_mispred;
  logic [NF-1:0][31:0]    fu_branch_loc;
  logic [NF-1:0]          fu_ready;
  logic [3:0]             rob_head;
  logic                   squash_valid;
  logic [3:0]             squash_tag;
  logic                   cdb_valid;
  logic [3:0]             cdb_tag;
  logic [31:0]            cdb_value;
  logic                   cdb_mispred;
  logic [31:0]            cdb_branch_loc;

  int vectors = 0;
  int miscompares = 0;

  // reference state: per-FU buffer contents and the expected bus
  bit          m_v   [NF];
  int          m_tag [NF];
  logic [31:0] m_val [NF];
  bit          m_mp  [NF];
  logic [31:0] m_bl  [NF];
  int          m_ptr;
  bit          e_v;
  int          e_tag;
  logic [31:0] e_val;
  bit          e_mp;
  logic [31:0] e_bl;
  int          bc_log[$];

  cdb_arbiter #(.NUM_FU(NF), .ROB_SZ(RS), .TAG_W(4)) dut (
    .clock(clock), .reset(reset), .fu_valid(fu_valid), .fu_tag(fu_tag),
    .fu_value(fu_value), .fu_mispred(fu_mispred), .fu_branch_loc(fu_branch_loc),
    .fu_ready(fu_ready), .rob_head(rob_head), .squash_valid(squash_valid),
    .squash_tag(squash_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_mispred(cdb_mispred), .cdb_branch_loc(cdb_branch_loc)
  );

  always #5 clock = ~clock;

  function automatic int age(int t, int h);
    return (t >= h) ? t - h : t + RS - h;
  endfunction

  task automatic check(string name, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_val[i] = '0; m_mp[i] = 0; m_bl[i] = '0;
    end
    m_ptr = 0; e_v = 0; e_tag = 0; e_val = '0; e_mp = 0; e_bl = '0;
  endtask

  // Called right after inputs change at a negedge; returns at the next negedge.
  task automatic cycle();
    bit sq [NF];
    bit rdy[NF];
    logic [NF-1:0] rvec;
    int w;
    int sa;
    #1;
    sa = age(int'(squash_tag), int'(rob_head));
    for (int i = 0; i < NF; i++)
      sq[i] = squash_valid && m_v[i] && (age(m_tag[i], int'(rob_head)) > sa);
    w = -1;
`ifdef CDB_ARB_AGE_PRIO_EN
    for (int i = 0; i < NF; i++)
      if (m_v[i] && !sq[i] && (w < 0 || age(m_tag[i], int'(rob_head)) < age(m_tag[w], int'(rob_head))))
        w = i;
`else
    for (int k = 0; k < NF; k++) begin
      int j;
      j = (m_ptr + k) % NF;
      if (w < 0 && m_v[j] && !sq[j]) w = j;
    end
`endif
    for (int i = 0; i < NF; i++) begin
      rdy[i]  = !m_v[i] || (w == i);
      rvec[i] = rdy[i];
    end
    check("fu_ready", 64'(fu_ready), 64'(rvec));
    @(posedge clock);
    if (w >= 0) begin
      e_v = 1; e_tag = m_tag[w]; e_val = m_val[w]; e_mp = m_mp[w]; e_bl = m_bl[w];
      m_v[w] = 0;
      m_ptr = (w + 1) % NF;
    end else begin
      e_v = 0; e_tag = 0; e_val = '0; e_mp = 0; e_bl = '0;
    end
    for (int i = 0; i < NF; i++) begin
      if (sq[i]) m_v[i] = 0;
      if (fu_valid[i] && rdy[i] && fu_tag[i] != 0 &&
          !(squash_valid && age(int'(fu_tag[i]), int'(rob_head)) > sa)) begin
        m_v[i] = 1; m_tag[i] = int'(fu_tag[i]); m_val[i] = fu_value[i];
        m_mp[i] = fu_mispred[i]; m_bl[i] = fu_branch_loc[i];
      end
    end
    @(negedge clock);
    check("cdb_valid", 64'(cdb_valid), 64'(e_v));
    check("cdb_tag", 64'(cdb_tag), 64'(e_tag));
    check("cdb_value", 64'(cdb_value), 64'(e_val));
    check("cdb_mispred", 64'(cdb_mispred), 64'(e_mp));
    check("cdb_branch_loc", 64'(cdb_branch_loc), 64'(e_bl));
    if (cdb_valid) bc_log.push_back(int'(cdb_tag));
  endtask

  task automatic idle(int n);
    fu_valid = '0;
    squash_valid = 0;
    repeat (n) cycle();
  endtask

  task automatic load(int fu, int tag, logic [31:0] val);
    fu_valid[fu] = 1'b1;
    fu_tag[fu] = 4'(tag);
    fu_value[fu] = val;
    fu_mispred[fu] = val[0];
    fu_branch_loc[fu] = ~val;
  endtask

  initial begin
    reset = 1; fu_valid = '0; fu_tag = '0; fu_value = '0; fu_mispred = '0;
    fu_branch_loc = '0; rob_head = 4'd1; squash_valid = 0; squash_tag = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    check("rst_fu_ready", 64'(fu_ready), 64'hF);
    reset = 0;

    // single result: visible two cycles after request, then idle
    load(0, 3, 32'hDEAD);
    cycle();
    fu_valid = '0;
    cycle();
    check("single_valid", 64'(cdb_valid), 64'd1);
    check("single_tag", 64'(cdb_tag), 64'd3);
    check("single_value", 64'(cdb_value), 64'hDEAD);
    cycle();
    check("single_idle", 64'(cdb_valid), 64'd0);
    idle(2);

    // every FU requests every cycle
    bc_log.delete();
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NF; i++) load(i, i + 1, 32'((i << 8) | c));
      cycle();
    end
    idle(6);
`ifndef CDB_ARB_AGE_PRIO_EN
    for (int k = 0; k < 8; k++) check("rr_order", 64'(bc_log[k]), 64'(((k + 1) % NF) + 1));
`endif

    // squash clears younger buffers only
    rob_head = 4'd6;
    load(0, 7, 32'h70); load(1, 8, 32'h80); load(2, 1, 32'h10); load(3, 2, 32'h20);
    cycle();
    fu_valid = '0; squash_valid = 1; squash_tag = 4'd8;
    bc_log.delete();
    cycle();
    squash_valid = 0;
    idle(5);
    check("squash_cnt", 64'(bc_log.size()), 64'd2);
    for (int k = 0; k < bc_log.size(); k++)
      check("squash_survivor", 64'(bc_log[k] == 7 || bc_log[k] == 8), 64'd1);

`ifdef CDB_ARB_AGE_PRIO_EN
    rob_head = 4'd7;
    load(0, 2, 32'h2); load(1, 8, 32'h8); load(2, 7, 32'h7);
    bc_log.delete();
    cycle();
    idle(5);
    check("age_cnt", 64'(bc_log.size()), 64'd3);
    check("age_0", 64'(bc_log[0]), 64'd7);
    check("age_1", 64'(bc_log[1]), 64'd8);
    check("age_2", 64'(bc_log[2]), 64'd2);
`endif

    // reset with buffers full
    rob_head = 4'd1;
    load(0, 1, 32'hA1); load(1, 2, 32'hA2); load(2, 3, 32'hA3);
    cycle();
    fu_valid = '0;
    cycle();
    reset = 1;
    #1;
    check("midrst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("midrst_fu_ready", 64'(fu_ready), 64'hF);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 0;
    bc_log.delete();
    idle(4);
    check("post_rst_quiet", 64'(bc_log.size()), 64'd0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NF; i++) begin
        fu_valid[i]      = ($urandom_range(0, 2) != 0);
        fu_tag[i]        = 4'($urandom_range(0, RS));
        fu_value[i]      = $urandom;
        fu_mispred[i]    = 1'($urandom);
        fu_branch_loc[i] = $urandom;
      end
      rob_head     = 4'($urandom_range(1, RS));
      squash_valid = ($urandom_range(0, 7) == 0);
      squash_tag   = 4'($urandom_range(1, RS));
      cycle();
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4: number of functional-unit requesters.
REQ-002 Parameter ROB_SZ, default 8: ROB entries; valid tags 1..ROB_SZ, tag 0 = none.
REQ-003 Parameter TAG_W, default 4: ROB tag width.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 fu_valid  in  NUM_FU  per-FU completion request.
REQ-007 fu_tag  in  NUM_FU x TAG_W  per-FU ROB tag.
REQ-008 fu_value  in  NUM_FU x 32  per-FU result.
REQ-009 fu_mispred  in  NUM_FU  per-FU branch-mispredict flag.
REQ-010 fu_branch_loc  in  NUM_FU x 32  per-FU branch target.
REQ-011 fu_ready  out  NUM_FU  FU may present a new result this cycle.
REQ-012 rob_head  in  TAG_W  current ROB head tag.
REQ-013 squash_valid  in  1  branch squash this cycle; squash_tag  in  TAG_W  squashing branch tag.
REQ-014 cdb_valid, cdb_tag, cdb_value, cdb_mispred, cdb_branch_loc  out  1/TAG_W/32/1/32  registered broadcast to ROB/RS.

Function
REQ-015 Each FU SHALL own a one-entry holding buffer; fu_ready[i] = buffer empty OR buffer granted this cycle (combinational).
REQ-016 Capture: fu_valid[i] && fu_ready[i] && fu_tag[i]!=0 SHALL load buffer i at the edge; fu_valid with tag 0 ignored.
REQ-017 Arbitration SHALL pick exactly one occupied buffer per cycle; the winner's contents drive cdb_* at the next edge (1-cycle latency buffer->CDB; 2 cycles FU->CDB minimum).
REQ-018 Default policy: round-robin; pointer advances to (winner+1) mod NUM_FU after each grant, unchanged when idle.
REQ-019 No occupied buffer: cdb_valid=0 and cdb_tag=0 next cycle; other cdb_* fields 0.
REQ-020 Age: age(t) = t>=rob_head ? t-rob_head : t+ROB_SZ-rob_head (wrap-around over 1..ROB_SZ).
REQ-021 squash_valid: every buffer with age(tag) > age(squash_tag) SHALL be cleared at the edge, and a same-cycle capture with such a tag SHALL be dropped.
REQ-022 A squashed buffer SHALL NOT be granted in the squash cycle; the CDB output never broadcasts a tag younger than a squash in the following cycle.
REQ-023 The squashing branch itself and older entries SHALL survive and keep their order.
REQ-024 Simultaneous grant and capture on the same FU SHALL broadcast old contents and hold new ones.
REQ-025 Buffered entries SHALL stay stable until granted or squashed (no drops under backpressure).

Reset
REQ-026 Reset SHALL clear all buffers, rr pointer to 0, all cdb_* to 0; fu_ready all 1 during/after reset.
REQ-027 Reset asserted mid-operation SHALL discard buffered and in-flight results immediately.

Configuration
REQ-028 CDB_ARB_AGE_PRIO_EN defined: winner SHALL be the occupied buffer with smallest age(tag), ties to lowest index; rr pointer unused.
REQ-029 CDB_ARB_AGE_PRIO_EN undefined: round-robin per REQ-018.

Structure
REQ-030 CDB packet typedef, ROB_TAG, age function SHALL live in the shared sys_defs package.
REQ-031 Arbitration SHALL be a sub-module cdb_rr_picker (request vector, pointer in; one-hot grant out).

Verification
REQ-032 Single FU0 tag 3 value 0xDEAD -> cdb_valid=1, tag 3, value 0xDEAD two cycles after request; idle next.
REQ-033 All 4 FUs request every cycle, tags 1..4 -> grants FU0,1,2,3,0... ; no result lost, fu_ready deasserts while waiting.
REQ-034 head=6, buffers tags 7,8,1,2, squash_tag 8 -> tags 1,2 cleared; 7,8 broadcast later.
REQ-035 Age mode, head=7, buffers tags 2,8,7 -> broadcast order 7,8,2.
REQ-036 Reset asserted with 3 buffers full -> cdb_valid=0, all fu_ready=1, nothing broadcast after release.
